// File: rtl/axi_lite_adder_slave_if.sv
// ==== axi_lite_adder_slave_if : AXI4-Lite S00_AXI bundle for the adder peripheral ====
// Rev 1.0
`default_nettype none

interface axi_lite_adder_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

`default_nettype wire

// File: rtl/axi_lite_adder_slave.sv
// ==== axi_lite_adder_slave : AXI4-Lite adder (OPA, OPB, SUM, STATUS); AXI_ADDER_WSTRB_EN enables byte strobes ====
// Rev 1.0
`default_nettype none

module axi_lite_adder_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  axi_lite_adder_slave_if.slave s_axi
);
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_e;
  typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_e;

  wr_state_e r_wr_state, w_wr_next;
  rd_state_e r_rd_state, w_rd_next;

  logic                            r_init;
  logic                            r_aw_held, r_w_held;
  logic [1:0]                      r_awsel;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] r_wstrb;
  logic [1:0]                      r_bresp;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_opa, r_opb, r_sum;
  logic                            r_carry, r_valid, r_sum_pend;
  logic [15:0]                     r_opcnt;

  logic                            w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [1:0]                      w_wr_sel;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_wr_data, w_wr_word, w_rd_word;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] w_wr_strb;
  logic                            w_unused;

  assign s_axi.S_AXI_AWREADY = r_init && (r_wr_state == WR_IDLE) && !r_aw_held;
  assign s_axi.S_AXI_WREADY  = r_init && (r_wr_state == WR_IDLE) && !r_w_held;
  assign s_axi.S_AXI_BVALID  = (r_wr_state == WR_RESP);
  assign s_axi.S_AXI_BRESP   = r_bresp;
  // Blocking AR for the cycle a sum update is pending keeps SUM/STATUS reads coherent
  assign s_axi.S_AXI_ARREADY = r_init && (r_rd_state == RD_IDLE) && !r_sum_pend;
  assign s_axi.S_AXI_RVALID  = (r_rd_state == RD_DATA);
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = c_RESP_OKAY;

  assign w_aw_hs   = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_w_hs    = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
  assign w_ar_hs   = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
  assign w_commit  = (r_wr_state == WR_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wr_sel  = r_aw_held ? r_awsel : s_axi.S_AXI_AWADDR[3:2];
  assign w_wr_data = r_w_held ? r_wdata : s_axi.S_AXI_WDATA;
  assign w_wr_strb = r_w_held ? r_wstrb : s_axi.S_AXI_WSTRB;

  assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, s_axi.S_AXI_AWADDR[1:0],
                      s_axi.S_AXI_ARADDR[1:0], w_wr_strb};

`ifdef AXI_ADDER_WSTRB_EN
  logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_old;
  always_comb begin
    w_wr_old  = w_wr_sel[0] ? r_opb : r_opa;
    w_wr_word = w_wr_old;
    for (int i = 0; i < C_S_AXI_DATA_WIDTH/8; i++) begin
      if (w_wr_strb[i]) w_wr_word[8*i +: 8] = w_wr_data[8*i +: 8];
    end
  end
`else
  assign w_wr_word = w_wr_data;
`endif

  always_comb begin
    w_rd_word = '0;
    case (s_axi.S_AXI_ARADDR[3:2])
      2'd0:    w_rd_word = r_opa;
      2'd1:    w_rd_word = r_opb;
      2'd2:    w_rd_word = r_sum;
      default: w_rd_word = {r_opcnt, 14'd0, r_valid, r_carry};
    endcase
  end

  always_comb begin
    w_wr_next = r_wr_state;
    w_rd_next = r_rd_state;
    if (r_wr_state == WR_IDLE) begin
      if (w_commit) w_wr_next = WR_RESP;
    end else if (s_axi.S_AXI_BREADY) begin
      w_wr_next = WR_IDLE;
    end
    if (r_rd_state == RD_IDLE) begin
      if (w_ar_hs) w_rd_next = RD_DATA;
    end else if (s_axi.S_AXI_RREADY) begin
      w_rd_next = RD_IDLE;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_wr_state <= WR_IDLE;
      r_rd_state <= RD_IDLE;
    end else begin
      r_wr_state <= w_wr_next;
      r_rd_state <= w_rd_next;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_init     <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awsel    <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= c_RESP_OKAY;
      r_rdata    <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_valid    <= 1'b0;
      r_sum_pend <= 1'b0;
      r_opcnt    <= '0;
    end else begin
      r_init <= 1'b1;
      if (w_aw_hs && !w_commit) begin
        r_aw_held <= 1'b1;
        r_awsel   <= s_axi.S_AXI_AWADDR[3:2];
      end
      if (w_w_hs && !w_commit) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi.S_AXI_WDATA;
        r_wstrb  <= s_axi.S_AXI_WSTRB;
      end
      if (r_sum_pend) begin
        {r_carry, r_sum} <= {1'b0, r_opa} + {1'b0, r_opb};
        r_valid          <= 1'b1;
        r_opcnt          <= r_opcnt + 16'd1;
        r_sum_pend       <= 1'b0;
      end
      // Placed after the sum update so a commit always wins on VALID/pending
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        if (w_wr_sel[1]) begin
          r_bresp <= c_RESP_SLVERR;
        end else begin
          r_bresp    <= c_RESP_OKAY;
          r_valid    <= 1'b0;
          r_sum_pend <= 1'b1;
          if (w_wr_sel[0]) r_opb <= w_wr_word;
          else             r_opa <= w_wr_word;
        end
      end
      if (w_ar_hs) r_rdata <= w_rd_word;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_axi_lite_adder_slave.sv
// ==== tb_axi_lite_adder_slave : directed vector bench for axi_lite_adder_slave ====
// Rev 1.0
`default_nettype none

module tb_axi_lite_adder_slave;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  axi_lite_adder_slave_if bus ();

  axi_lite_adder_slave dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .s_axi        (bus)
  );

  typedef struct {
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [1:0]  wresp;
    logic [3:0]  ra;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[13];

`ifdef AXI_ADDER_WSTRB_EN
  localparam logic [31:0] c_OPA_MERGED = 32'h11BB33DD;
`else
  localparam logic [31:0] c_OPA_MERGED = 32'hAABBCCDD;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got=timeout want=handshake", name);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int   n;
    logic aw_go, w_go;
    resp = 2'bxx;
    @(negedge clk);
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    n = 0;
    while ((bus.S_AXI_AWVALID || bus.S_AXI_WVALID) && n < 50) begin
      aw_go = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_go  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(negedge clk);
      if (aw_go) bus.S_AXI_AWVALID = 1'b0;
      if (w_go)  bus.S_AXI_WVALID  = 1'b0;
      n++;
    end
    while (!bus.S_AXI_BVALID && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.S_AXI_BVALID) resp = bus.S_AXI_BRESP;
    else timeout("write_handshake");
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    d    = 'x;
    resp = 2'bxx;
    @(negedge clk);
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    while (!bus.S_AXI_RVALID && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.S_AXI_RVALID) begin
      d    = bus.S_AXI_RDATA;
      resp = bus.S_AXI_RRESP;
    end else begin
      timeout("read_handshake");
    end
    @(negedge clk);
    bus.S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=no_finish want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          n, low;
    logic        flag_a, flag_b;

    tbl[0]  = '{4'h0, 32'h00000001, 4'hF, 2'b00, 4'h0, 32'h00000001};
    tbl[1]  = '{4'h4, 32'h00000002, 4'hF, 2'b00, 4'h8, 32'h00000003};
    tbl[2]  = '{4'hC, 32'h12345678, 4'hF, 2'b10, 4'hC, 32'h00020002};
    tbl[3]  = '{4'h0, 32'hFFFFFFFF, 4'hF, 2'b00, 4'h0, 32'hFFFFFFFF};
    tbl[4]  = '{4'h4, 32'h00000001, 4'hF, 2'b00, 4'h8, 32'h00000000};
    tbl[5]  = '{4'h8, 32'hDEADBEEF, 4'hF, 2'b10, 4'hC, 32'h00040003};
    tbl[6]  = '{4'hE, 32'h00000000, 4'hF, 2'b10, 4'h8, 32'h00000000};
    tbl[7]  = '{4'h1, 32'h00000005, 4'hF, 2'b00, 4'hC, 32'h00050002};
    tbl[8]  = '{4'h4, 32'h7FFFFFFF, 4'hF, 2'b00, 4'h8, 32'h80000004};
    tbl[9]  = '{4'h0, 32'h80000001, 4'hF, 2'b00, 4'hC, 32'h00070003};
    tbl[10] = '{4'h0, 32'h11223344, 4'hF, 2'b00, 4'h0, 32'h11223344};
    tbl[11] = '{4'h0, 32'hAABBCCDD, 4'h5, 2'b00, 4'h0, c_OPA_MERGED};
    tbl[12] = '{4'h4, 32'h00000000, 4'h0, 2'b00, 4'hC, 32'h000A0002};

    rst = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ready_valid", {27'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                              bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'h0);
    check("rst_resp", {28'd0, bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 32'h0);
    check("rst_rdata", bus.S_AXI_RDATA, 32'h0);
    rst = 1'b0;
    #1;
    check("ready_before_edge", {29'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'h0);
    @(negedge clk);
    check("ready_after_edge", {29'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'h7);
    do_read(4'hC, rd, resp);
    check("status_reset", rd, 32'h0);

    for (int i = 0; i < 13; i++) begin
      do_write(tbl[i].wa, tbl[i].wd, tbl[i].ws, resp);
      check($sformatf("vec%0d_bresp", i), {30'd0, resp}, {30'd0, tbl[i].wresp});
      do_read(tbl[i].ra, rd, resp);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      if (resp !== 2'b00) check($sformatf("vec%0d_rresp", i), {30'd0, resp}, 32'h0);
    end

    // Split write: W three cycles ahead of AW, B held off for five cycles
    @(negedge clk);
    bus.S_AXI_WDATA  = 32'h00000009;
    bus.S_AXI_WSTRB  = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b0;
    check("split_wready", {31'd0, bus.S_AXI_WREADY}, 32'h1);
    @(negedge clk);
    bus.S_AXI_WVALID = 1'b0;
    flag_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (bus.S_AXI_WREADY || bus.S_AXI_BVALID || !bus.S_AXI_AWREADY) flag_a = 1'b1;
      @(negedge clk);
    end
    check("split_wait_state", {31'd0, flag_a}, 32'h0);
    bus.S_AXI_AWADDR  = 4'h4;
    bus.S_AXI_AWVALID = 1'b1;
    check("split_awready", {31'd0, bus.S_AXI_AWREADY}, 32'h1);
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    flag_a = 1'b0;
    flag_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!bus.S_AXI_BVALID || bus.S_AXI_BRESP !== 2'b00) flag_a = 1'b1;
      if (bus.S_AXI_AWREADY || bus.S_AXI_WREADY) flag_b = 1'b1;
      @(negedge clk);
    end
    check("split_b_stable", {31'd0, flag_a}, 32'h0);
    check("split_no_ready", {31'd0, flag_b}, 32'h0);
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
    check("split_after_b", {30'd0, bus.S_AXI_AWREADY, bus.S_AXI_BVALID}, 32'h2);
    do_read(4'hC, rd, resp);
    check("split_single_commit", rd, 32'h000B0002);
    do_read(4'h8, rd, resp);
    check("split_sum", rd, c_OPA_MERGED + 32'h9);

    // Read SUM straight after an OPA commit
    @(negedge clk);
    bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA  = 32'h00000100; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b1;
    check("raw_wr_ready", {30'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'h3);
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    check("raw_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'h1);
    bus.S_AXI_ARADDR  = 4'h8;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    low = 0;
    n   = 0;
    while (!bus.S_AXI_ARREADY && n < 20) begin
      low++;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
      n++;
    end
    check("raw_arready_low_cycles", low, 32'd1);
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.S_AXI_RVALID) timeout("raw_rvalid");
    check("raw_arready_while_rvalid", {31'd0, bus.S_AXI_ARREADY}, 32'h0);
    check("raw_sum", bus.S_AXI_RDATA, 32'h00000109);
    @(negedge clk);
    bus.S_AXI_RREADY = 1'b0;

    // Read accepted on the commit edge sees the pre-write OPA
    @(negedge clk);
    bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA  = 32'h00000200; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARADDR = 4'h0; bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    check("sim_readies", {29'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'h7);
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    check("sim_valids", {30'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'h3);
    check("sim_old_opa", bus.S_AXI_RDATA, 32'h00000100);
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    do_read(4'h0, rd, resp);
    check("sim_new_opa", rd, 32'h00000200);
    do_read(4'hC, rd, resp);
    check("sim_status", rd, 32'h000D0002);

    // Reset with a read response outstanding and a lone W captured
    @(negedge clk);
    bus.S_AXI_ARADDR = 4'h0; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    check("mid_rvalid_before", {31'd0, bus.S_AXI_RVALID}, 32'h1);
    bus.S_AXI_WDATA = 32'h00000077; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_WVALID = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_outputs", {29'd0, bus.S_AXI_RVALID, bus.S_AXI_BVALID, bus.S_AXI_WREADY}, 32'h0);
    check("mid_rst_rdata", bus.S_AXI_RDATA, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    flag_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.S_AXI_BVALID) flag_a = 1'b1;
      @(negedge clk);
    end
    check("mid_no_stale_w", {31'd0, flag_a}, 32'h0);
    bus.S_AXI_WDATA = 32'h00000055; bus.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_WVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_BVALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.S_AXI_BVALID) timeout("mid_bvalid");
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
    do_read(4'h4, rd, resp);
    check("mid_opb", rd, 32'h00000055);
    do_read(4'hC, rd, resp);
    check("mid_status", rd, 32'h00010002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
